// File: rtl/ex_muldiv_if.sv
// ----------------------------------------------------------------------------
// ex_muldiv_if
//   Request/result bundle between the EX stage and the multi-cycle
//   multiply/divide sequencer.
//
//   start     EX -> seq   request valid (ALU func decodes a mul/div op)
//   op        EX -> seq   0=MULU 1=MUL 2=DIVU 3=DIV
//   data_a    EX -> seq   multiplicand / dividend
//   data_b    EX -> seq   multiplier / divisor
//   flush     EX -> seq   abort the in-flight operation
//   stall     seq -> EX   hold PC and EX stage registers
//   done      seq -> EX   one-cycle pulse, hi/lo valid
//   hi        seq -> EX   product upper half / remainder
//   lo        seq -> EX   product lower half / quotient
//   div_zero  seq -> EX   last completed divide had a zero divisor
//
//   Modport master is the EX-stage side, slave is the sequencer.
// ----------------------------------------------------------------------------
interface ex_muldiv_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] data_a;
   logic [WIDTH-1:0] data_b;
   logic             flush;
   logic             stall;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             div_zero;

   modport master (
      output start, op, data_a, data_b, flush,
      input  stall, done, hi, lo, div_zero
   );

   modport slave (
      input  start, op, data_a, data_b, flush,
      output stall, done, hi, lo, div_zero
   );
endinterface

// File: rtl/ex_muldiv_sequencer.sv
// ----------------------------------------------------------------------------
// ex_muldiv_sequencer
//   Multi-cycle multiply/divide unit sitting beside the EX-stage ALU.
//   Multiplies by shift-add and divides by restoring division, one bit per
//   cycle on operand magnitudes; signs are reapplied in a final fix-up cycle.
//   The pipeline is held via stall until the {hi,lo} result is ready.
//
//   clk    in  clock, rising edge
//   reset  in  asynchronous, active-low; clears all state
//   bus    slave side of ex_muldiv_if (start/op/data_a/data_b/flush in,
//          stall/done/hi/lo/div_zero out)
//
//   Sequence: IDLE -> PREP -> RUN x WIDTH -> FIX -> DONE -> IDLE, or
//   IDLE -> PREP -> DONE for a divide by zero. flush returns to IDLE from
//   any busy state without touching the result registers.
// ----------------------------------------------------------------------------
module ex_muldiv_sequencer #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 5
) (
   input  logic        clk,
   input  logic        reset,
   ex_muldiv_if.slave  bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PREP,
      S_RUN,
      S_FIX,
      S_DONE
   } state_t;

   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic             is_signed_q, is_div_q;
   logic             sign_a_q, sign_b_q;
   logic [WIDTH-1:0] mag_a_q, mag_b_q;
   logic [WIDTH-1:0] acc_hi, acc_lo;
   logic [WIDTH-1:0] hi_q, lo_q;
   logic             dz_q;
   logic             stall_c;

   // Two's-complement negate when neg is set (single- and double-width)
   function automatic logic [WIDTH-1:0] cond_neg_w(input logic [WIDTH-1:0] v,
                                                   input logic neg);
      return neg ? (~v + WIDTH'(1)) : v;
   endfunction

   function automatic logic [2*WIDTH-1:0] cond_neg_d(input logic [2*WIDTH-1:0] v,
                                                     input logic neg);
      return neg ? (~v + (2*WIDTH)'(1)) : v;
   endfunction

   // Operand decode at request time
   logic signed [WIDTH-1:0] a_s, b_s;
   logic                    req_signed, req_sign_a, req_sign_b;
   logic                    accept;

   assign a_s        = bus.data_a;
   assign b_s        = bus.data_b;
   assign req_signed = bus.op[0];
   assign req_sign_a = req_signed && (a_s < 0);
   assign req_sign_b = req_signed && (b_s < 0);
   assign accept     = bus.start && !bus.flush;

   // Iteration datapath
   logic [WIDTH:0]       mul_sum;
   logic [WIDTH+1:0]     div_diff;
   logic                 div_fits;
   logic                 div_by_zero;
   logic                 neg_result;
   logic [2*WIDTH-1:0]   prod_fix;

   // Multiply: accumulate the multiplicand into the upper half when the
   // current multiplier bit (acc_lo[0]) is set, then shift the pair right.
   assign mul_sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_a_q} : '0);
   // Divide: shift the next dividend bit into the partial remainder and
   // trial-subtract; the extra top bit is the borrow.
   assign div_diff    = {1'b0, acc_hi, acc_lo[WIDTH-1]} - {2'b00, mag_b_q};
   assign div_fits    = !div_diff[WIDTH+1];
   assign div_by_zero = is_div_q && (mag_b_q == '0);
   // Signs are only latched for signed ops, so this is 0 for MULU/DIVU
   assign neg_result  = sign_a_q ^ sign_b_q;
   assign prod_fix    = cond_neg_d({acc_hi, acc_lo}, neg_result);

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next state and stall
   always_comb begin
      state_nxt = state;
      stall_c   = 1'b0;
      case (state)
         S_IDLE: begin
            if (accept) begin
               state_nxt = S_PREP;
               stall_c   = 1'b1;
            end
         end
         S_PREP: begin
            state_nxt = div_by_zero ? S_DONE : S_RUN;
            stall_c   = 1'b1;
         end
         S_RUN: begin
            if (cnt == LAST_ITER) state_nxt = S_FIX;
            stall_c = 1'b1;
         end
         S_FIX: begin
            state_nxt = S_DONE;
            stall_c   = 1'b1;
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
      if (state != S_IDLE && bus.flush) state_nxt = S_IDLE;
   end

   // Operand latch, iteration and result registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt         <= '0;
         is_signed_q <= 1'b0;
         is_div_q    <= 1'b0;
         sign_a_q    <= 1'b0;
         sign_b_q    <= 1'b0;
         mag_a_q     <= '0;
         mag_b_q     <= '0;
         acc_hi      <= '0;
         acc_lo      <= '0;
         hi_q        <= '0;
         lo_q        <= '0;
         dz_q        <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  is_signed_q <= req_signed;
                  is_div_q    <= bus.op[1];
                  sign_a_q    <= req_sign_a;
                  sign_b_q    <= req_sign_b;
                  mag_a_q     <= cond_neg_w(bus.data_a, req_sign_a);
                  mag_b_q     <= cond_neg_w(bus.data_b, req_sign_b);
               end
            end
            S_PREP: begin
               cnt    <= '0;
               acc_hi <= '0;
               acc_lo <= is_div_q ? mag_a_q : mag_b_q;
               if (div_by_zero && !bus.flush) begin
                  // Re-negating the magnitude recovers the raw dividend
                  hi_q <= cond_neg_w(mag_a_q, sign_a_q);
                  lo_q <= '1;
                  dz_q <= 1'b1;
               end
            end
            S_RUN: begin
               cnt <= cnt + CNT_W'(1);
               if (is_div_q) begin
                  acc_hi <= div_fits ? div_diff[WIDTH-1:0]
                                     : {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
                  acc_lo <= {acc_lo[WIDTH-2:0], div_fits};
               end else begin
                  acc_hi <= mul_sum[WIDTH:1];
                  acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
               end
            end
            S_FIX: begin
               if (!bus.flush) begin
                  dz_q <= 1'b0;
                  if (is_div_q) begin
                     // Quotient sign from sign_a^sign_b, remainder follows the dividend
                     hi_q <= cond_neg_w(acc_hi, sign_a_q);
                     lo_q <= cond_neg_w(acc_lo, neg_result);
                  end else begin
                     hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                     lo_q <= prod_fix[WIDTH-1:0];
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.stall    = stall_c;
   assign bus.done     = (state == S_DONE);
   assign bus.hi       = hi_q;
   assign bus.lo       = lo_q;
   assign bus.div_zero = dz_q;

   // is_signed_q is folded into the latched signs; kept for debug visibility
   logic unused_ok;
   assign unused_ok = is_signed_q;

endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
// ----------------------------------------------------------------------------
// tb_ex_muldiv_sequencer
//   Directed bench for ex_muldiv_sequencer: reset values, unsigned/signed
//   multiply and divide, divide-by-zero, overflow wrap, flush mid-run,
//   flush beating start, asynchronous reset mid-run and ignored re-start.
// ----------------------------------------------------------------------------
module tb_ex_muldiv_sequencer;

   logic clk;
   logic reset;
   int   total;
   int   bad;

   ex_muldiv_if #(.WIDTH(32)) bus ();

   ex_muldiv_sequencer #(.WIDTH(32), .CNT_W(5)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issue one op, check stall through the busy window, latency and results
   task automatic run_op(input string tag, input logic [1:0] o,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el,
                         input logic ed, input int elat);
      int cyc;
      bit stall_ok;
      bus.op     = o;
      bus.data_a = a;
      bus.data_b = b;
      bus.start  = 1'b1;
      #1;
      chk({tag, "_stall_c0"}, 64'(bus.stall), 64'd1);
      tick();
      bus.start = 1'b0;
      cyc       = 1;
      stall_ok  = 1'b1;
      while (bus.done !== 1'b1 && cyc < 60) begin
         if (bus.stall !== 1'b1) stall_ok = 1'b0;
         tick();
         cyc++;
      end
      chk({tag, "_latency"}, 64'(cyc), 64'(elat));
      chk({tag, "_stall_busy"}, 64'(stall_ok), 64'd1);
      chk({tag, "_stall_done"}, 64'(bus.stall), 64'd0);
      chk({tag, "_hi"}, 64'(bus.hi), 64'(eh));
      chk({tag, "_lo"}, 64'(bus.lo), 64'(el));
      chk({tag, "_dz"}, 64'(bus.div_zero), 64'(ed));
      tick();
      chk({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
   endtask

   initial begin
      int ndone;
      logic [31:0] cap_hi, cap_lo;
      total      = 0;
      bad        = 0;
      reset      = 1'b0;
      bus.start  = 1'b0;
      bus.op     = 2'd0;
      bus.data_a = '0;
      bus.data_b = '0;
      bus.flush  = 1'b0;

      // Reset state
      repeat (3) tick();
      chk("rst_stall", 64'(bus.stall), 64'd0);
      chk("rst_done",  64'(bus.done),  64'd0);
      chk("rst_hi",    64'(bus.hi),    64'd0);
      chk("rst_lo",    64'(bus.lo),    64'd0);
      chk("rst_dz",    64'(bus.div_zero), 64'd0);
      reset = 1'b1;
      tick();

      // Multiply / divide vectors
      run_op("mulu_max",  2'd0, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, 1'b0, 35);
      run_op("mulu_mid",  2'd0, 32'h12345678, 32'd9, 32'h00000000, 32'hA3D70A38, 1'b0, 35);
      run_op("mul_neg",   2'd1, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 35);
      run_op("div_neg_a", 2'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 35);
      run_op("divu_zero", 2'd2, 32'd100, 32'd0, 32'd100, 32'hFFFFFFFF, 1'b1, 2);
      run_op("divu_7",    2'd2, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 35);
      run_op("div_ovf",   2'd3, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, 35);
      run_op("div_neg_b", 2'd3, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b0, 35);

      // Flush at RUN counter=10: cycle 12 after the start edge
      bus.op     = 2'd0;
      bus.data_a = 32'd5;
      bus.data_b = 32'd5;
      bus.start  = 1'b1;
      tick();
      bus.start = 1'b0;
      ndone = 0;
      repeat (11) begin
         if (bus.done === 1'b1) ndone++;
         tick();
      end
      bus.flush = 1'b1;
      #1;
      chk("flush_stall_during", 64'(bus.stall), 64'd1);
      tick();
      bus.flush = 1'b0;
      #1;
      chk("flush_stall_after", 64'(bus.stall), 64'd0);
      chk("flush_no_done",     64'(bus.done | (ndone != 0)), 64'd0);
      chk("flush_hi_kept",     64'(bus.hi), 64'd1);
      chk("flush_lo_kept",     64'(bus.lo), 64'hFFFFFFFD);
      run_op("after_flush", 2'd0, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 35);

      // flush and start together in IDLE: request dropped
      bus.op     = 2'd0;
      bus.data_a = 32'd3;
      bus.data_b = 32'd3;
      bus.start  = 1'b1;
      bus.flush  = 1'b1;
      #1;
      chk("idle_flush_stall", 64'(bus.stall), 64'd0);
      tick();
      bus.start = 1'b0;
      bus.flush = 1'b0;
      ndone = 0;
      repeat (40) begin
         if (bus.done === 1'b1 || bus.stall === 1'b1) ndone++;
         tick();
      end
      chk("idle_flush_dropped", 64'(ndone), 64'd0);
      chk("idle_flush_lo", 64'(bus.lo), 64'd42);

      // Asynchronous reset at RUN counter=20 (cycle 22)
      bus.op     = 2'd2;
      bus.data_a = 32'd1000;
      bus.data_b = 32'd3;
      bus.start  = 1'b1;
      tick();
      bus.start = 1'b0;
      repeat (21) tick();
      #2;
      reset = 1'b0;
      #1;
      chk("arst_stall", 64'(bus.stall), 64'd0);
      chk("arst_done",  64'(bus.done),  64'd0);
      chk("arst_hi",    64'(bus.hi),    64'd0);
      chk("arst_lo",    64'(bus.lo),    64'd0);
      chk("arst_dz",    64'(bus.div_zero), 64'd0);
      tick();
      reset = 1'b1;
      tick();

      // Start re-pulsed mid-operation is ignored: exactly one done
      bus.op     = 2'd2;
      bus.data_a = 32'd1000;
      bus.data_b = 32'd3;
      bus.start  = 1'b1;
      tick();
      bus.start = 1'b0;
      ndone  = 0;
      cap_hi = '0;
      cap_lo = '0;
      for (int c = 1; c < 50; c++) begin
         if (c == 3) begin
            bus.op     = 2'd0;
            bus.data_a = 32'd9;
            bus.data_b = 32'd9;
            bus.start  = 1'b1;
         end
         if (c == 6) bus.start = 1'b0;
         #1;
         if (bus.done === 1'b1) begin
            ndone++;
            cap_hi = bus.hi;
            cap_lo = bus.lo;
            chk("restart_latency", 64'(c), 64'd35);
         end
         tick();
      end
      chk("restart_one_done", 64'(ndone), 64'd1);
      chk("restart_hi", 64'(cap_hi), 64'd1);
      chk("restart_lo", 64'(cap_lo), 64'd333);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
